spi_frame_loader: RTL and testbench
===================================

Name: spi_frame_loader

Overview:
- Upstream stage of the NeoPixel chain: SPI slave (mode 0, MSB first) that receives one full frame of GRB bytes into an internal byte-wide frame RAM.
- Exposes a synchronous read port to the driver (address out, data in, from the driver's view).
- Hands each complete frame to the driver with a one-cycle start pulse.

Parameters:
- LEDS, 200, number of pixels; frame length FRAME_BYTES = LEDS*3.
- ADDR_W, $clog2(LEDS*3), width of RAM address and byte counter.

Ports:
- i_clk  in  1  system clock; must be at least 8x SCLK.
- i_rst  in  1  asynchronous active-high reset.
- i_spi_sclk  in  1  SPI clock, asynchronous to i_clk.
- i_spi_mosi  in  1  SPI data, asynchronous.
- i_spi_cs_n  in  1  SPI chip select, active low, asynchronous.
- i_rd_addr  in  ADDR_W  driver read address.
- o_rd_data  out  8  RAM byte at i_rd_addr, registered, 1-cycle latency.
- i_drv_busy  in  1  driver busy.
- o_start  out  1  one-cycle pulse; starts driver output.
- o_ready  out  1  high when no commit is pending and driver is idle; host may send next frame.
- o_frame_ok  out  1  one-cycle pulse when a complete frame is committed.
- o_err_short  out  1  one-cycle pulse when CS rises with fewer than FRAME_BYTES bytes.
- o_err_over  out  1  one-cycle pulse, at most once per CS window, when the first extra byte arrives.

Behaviour:
- Reset: all outputs 0, except o_ready = 1 when i_drv_busy = 0. Byte counter 0, state IDLE, pending flag 0. RAM contents are not reset.
- Synchronisers:
  - SCLK, MOSI and CS_n each pass through 2 flops; a third flop provides edge detection.
  - MOSI is sampled on the detected SCLK rising edge using the synchronised MOSI value.
- Byte assembly:
  - Shift register collects MSB first.
  - A bit counter wraps 7->0; on the 8th rising edge, the byte-valid strobe fires for one cycle.
  - CS_n high clears the bit counter and shift register; partial bytes are discarded.
- State machine: IDLE, RECV, OVER, COMMIT.
  - IDLE: on CS_n falling edge, byte counter = 0, go to RECV. SCLK edges in IDLE are ignored.
  - RECV, byte strobe: RAM[counter] <= byte in the same cycle, counter++.
    - When counter reaches FRAME_BYTES, go to OVER; this is the normal full-frame case.
    - Counter never wraps.
  - RECV, CS_n rising edge: with counter < FRAME_BYTES, pulse o_err_short and go to IDLE. Written bytes remain in RAM and no start is issued.
  - OVER, byte strobe: no RAM write; pulse o_err_over on the first extra byte only.
  - OVER, CS_n rising edge: pulse o_frame_ok, set pending, go to COMMIT.
  - COMMIT: one cycle, go to IDLE.
- Start handoff:
  - While pending = 1 and i_drv_busy = 0, drive o_start high for exactly one cycle and clear pending.
  - If the driver is busy, pending holds until busy falls; o_start rises the cycle after busy is seen low.
  - A second committed frame while pending is set merges into the same pending; only one start is issued.
- Frame RAM:
  - FRAME_BYTES x 8, one write port (SPI side) and one read port (driver side), inferred as simple dual-port block RAM.
  - Read data is registered.
  - Same-address read and write in the same cycle returns old data.
- Tearing: a new SPI frame is accepted while the driver is busy. The host must gate on o_ready; the block does not block writes.
- Simultaneous CS_n rise and byte strobe in the same cycle: the byte is written first, then the CS_n rise is evaluated with the updated counter.
- Reset mid-frame: returns to IDLE, pending cleared, no pulses generated.

Decomposition:
- Shared package neopixel_pkg: LEDS default, FRAME_BYTES function, and a loader state enum typedef (2 bits).
- Sub-module spi_byte_rx: synchronisers, edge detect and shift register. Outputs byte[7:0], byte_valid, cs_fall, cs_rise.
- The RAM is inferred inline in spi_frame_loader.

Test Plan (LEDS=4, FRAME_BYTES=12, i_clk 50 MHz, SCLK 5 MHz):
- Normal frame, driver idle:
  - Stimulus: send bytes 0x00..0x0B, then raise CS.
  - Response: o_frame_ok pulse, then o_start one cycle later. Reading addr 5 returns 0x05 on the next cycle.
- Short frame:
  - Stimulus: send 7 bytes, then raise CS.
  - Response: o_err_short pulse, o_start never asserts, pending = 0, o_ready stays 1.
- Overrun:
  - Stimulus: send 15 bytes (last three 0xAA).
  - Response: exactly one o_err_over pulse at byte 13, RAM[0..11] intact. o_frame_ok and o_start fire on CS rise.
- Driver busy:
  - Stimulus: hold i_drv_busy = 1 and complete a frame; drop busy 100 cycles later.
  - Response: o_ready = 0 throughout; one o_start the cycle after busy falls.
- Partial byte and reset:
  - Stimulus: raise CS after 3 bits, then send a full frame.
  - Response: RAM gets bytes from offset 0 with no bit slip.
  - Stimulus: assert i_rst mid-frame.
  - Response: all pulses 0, state IDLE, the next full frame loads correctly.

Source files
------------

// File: rtl/neopixel_pkg.sv
// neopixel_pkg: shared frame sizing and loader state encoding for the NeoPixel chain
package neopixel_pkg;
  localparam int LEDS_DEF = 200;
  function automatic int frame_bytes(input int leds);
    return leds * 3;
  endfunction
  typedef enum logic [1:0] {S_IDLE, S_RECV, S_OVER, S_COMMIT} loader_state_t;
endpackage

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises SPI mode-0 pins into i_clk and assembles MSB-first bytes
module spi_byte_rx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk,
  input  logic       i_mosi,
  input  logic       i_cs_n,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_cs_fall,
  output logic       o_cs_rise
);
  logic [2:0] r_sclk_s;
  logic [2:0] r_cs_s;
  logic [1:0] r_mosi_s;
  logic [2:0] r_bit;
  logic [6:0] r_shift;
  logic       w_sclk_rise;

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign o_cs_fall   = ~r_cs_s[1] & r_cs_s[2];
  assign o_cs_rise   = r_cs_s[1] & ~r_cs_s[2];

  // two-flop synchronisers plus a third stage for edge detection; CS idles deasserted
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_sclk_s <= '0;
      r_cs_s   <= '1;
      r_mosi_s <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], i_sclk};
      r_cs_s   <= {r_cs_s[1:0], i_cs_n};
      r_mosi_s <= {r_mosi_s[0], i_mosi};
    end

  // shift in on each SCLK rise; deasserted CS discards any partial byte
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_bit        <= '0;
      r_shift      <= '0;
      o_byte       <= '0;
      o_byte_valid <= 1'b0;
    end else begin
      o_byte_valid <= 1'b0;
      if (r_cs_s[1]) begin
        r_bit   <= '0;
        r_shift <= '0;
      end else if (w_sclk_rise) begin
        r_shift <= {r_shift[5:0], r_mosi_s[1]};
        r_bit   <= r_bit + 1'b1;
        if (r_bit == 3'd7) begin
          o_byte       <= {r_shift, r_mosi_s[1]};
          o_byte_valid <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/spi_frame_loader.sv
// spi_frame_loader: receives one GRB frame over SPI into a frame RAM and hands it to the driver
module spi_frame_loader
  import neopixel_pkg::*;
#(
  parameter int LEDS   = LEDS_DEF,
  parameter int ADDR_W = $clog2(LEDS * 3)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_spi_sclk,
  input  logic              i_spi_mosi,
  input  logic              i_spi_cs_n,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [7:0]        o_rd_data,
  input  logic              i_drv_busy,
  output logic              o_start,
  output logic              o_ready,
  output logic              o_frame_ok,
  output logic              o_err_short,
  output logic              o_err_over
);
  localparam int FB = frame_bytes(LEDS);
  localparam logic [ADDR_W-1:0] FB_L = ADDR_W'(FB);

  logic [7:0]        r_ram [0:FB-1];
  loader_state_t     r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_pending;
  logic              r_over_seen;
  logic [7:0]        w_byte;
  logic              w_byte_valid;
  logic              w_cs_fall;
  logic              w_cs_rise;
  logic              w_wr;
  logic [ADDR_W-1:0] w_cnt_upd;

  spi_byte_rx u_rx (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_sclk      (i_spi_sclk),
    .i_mosi      (i_spi_mosi),
    .i_cs_n      (i_spi_cs_n),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_cs_fall   (w_cs_fall),
    .o_cs_rise   (w_cs_rise)
  );

  assign w_wr      = (r_state == S_RECV) && w_byte_valid;
  assign w_cnt_upd = w_wr ? r_cnt + 1'b1 : r_cnt;
  assign o_ready   = !r_pending && !i_drv_busy;

  // SPI-side write port; a byte landing with CS rise is counted before CS is judged
  always_ff @(posedge i_clk)
    if (w_wr) r_ram[r_cnt] <= w_byte;

  // driver-side registered read; same-address write returns the old byte
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) o_rd_data <= '0;
    else       o_rd_data <= r_ram[i_rd_addr];

  // frame state machine and start handoff; a commit after the handoff keeps pending set
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pending   <= 1'b0;
      r_over_seen <= 1'b0;
      o_start     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_over  <= 1'b0;
    end else begin
      o_start     <= 1'b0;
      o_frame_ok  <= 1'b0;
      o_err_short <= 1'b0;
      o_err_over  <= 1'b0;
      if (r_pending && !i_drv_busy) begin
        o_start   <= 1'b1;
        r_pending <= 1'b0;
      end
      case (r_state)
        S_IDLE:
          if (w_cs_fall) begin
            r_cnt       <= '0;
            r_over_seen <= 1'b0;
            r_state     <= S_RECV;
          end
        S_RECV: begin
          r_cnt <= w_cnt_upd;
          if (w_cs_rise && w_cnt_upd == FB_L) begin
            o_frame_ok <= 1'b1;
            r_pending  <= 1'b1;
            r_state    <= S_COMMIT;
          end else if (w_cs_rise) begin
            o_err_short <= 1'b1;
            r_state     <= S_IDLE;
          end else if (w_cnt_upd == FB_L) r_state <= S_OVER;
        end
        S_OVER: begin
          if (w_byte_valid && !r_over_seen) begin
            o_err_over  <= 1'b1;
            r_over_seen <= 1'b1;
          end
          if (w_cs_rise) begin
            o_frame_ok <= 1'b1;
            r_pending  <= 1'b1;
            r_state    <= S_COMMIT;
          end
        end
        S_COMMIT: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_frame_loader.sv
// tb_spi_frame_loader: randomized frames against a frame-level reference of the loader
module tb_spi_frame_loader;
  localparam int FB = 12;
  logic       clk = 0, rst = 1, sclk = 0, mosi = 0, cs_n = 1, busy = 0;
  logic [3:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic       start, ready, frame_ok, err_short, err_over;
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_start = 0, n_ok = 0, n_short = 0, n_over = 0, n_ready = 0;
  int start_cyc = 0, ok_cyc = 0;
  logic [7:0] ref_ram [FB];
  bit         ref_valid [FB];

  spi_frame_loader #(.LEDS(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_spi_sclk(sclk), .i_spi_mosi(mosi), .i_spi_cs_n(cs_n),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .i_drv_busy(busy), .o_start(start),
    .o_ready(ready), .o_frame_ok(frame_ok), .o_err_short(err_short), .o_err_over(err_over)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (start) begin n_start++; start_cyc = cyc; end
    if (frame_ok) begin n_ok++; ok_cyc = cyc; end
    if (err_short) n_short++;
    if (err_over) n_over++;
    if (ready) n_ready++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic spi_bit(input logic b);
    mosi = b; #100 sclk = 1; #100 sclk = 0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
  endtask

  task automatic check_ram();
    for (int a = 0; a < FB; a++) if (ref_valid[a]) begin
      @(negedge clk) rd_addr = 4'(a);
      @(negedge clk) check($sformatf("ram[%0d]", a), int'(rd_data), int'(ref_ram[a]));
    end
  endtask

  // one CS window of n bytes; bytes past the frame length are 0xAA
  task automatic do_frame(input int n, input bit seq, input bit busy_exp);
    int s0 = n_start, o0 = n_ok, sh0 = n_short, ov0 = n_over;
    logic [7:0] b;
    cs_n = 0; #200;
    for (int i = 0; i < n; i++) begin
      b = (i >= FB) ? 8'hAA : seq ? 8'(i) : 8'($urandom);
      if (i < FB) begin ref_ram[i] = b; ref_valid[i] = 1; end
      spi_byte(b);
    end
    #200 cs_n = 1;
    wait_clks(12);
    check("frame_ok", n_ok - o0, int'(n >= FB));
    check("start", n_start - s0, (busy_exp || n < FB) ? 0 : 1);
    check("err_short", n_short - sh0, int'(n < FB));
    check("err_over", n_over - ov0, int'(n > FB));
    check("ready", int'(ready), int'(!busy_exp));
    if (n >= FB && !busy_exp) check("start_after_ok", start_cyc - ok_cyc, 1);
    #200;
  endtask

  initial begin
    int s0, o0, sh0, ov0, r0, drop_cyc;
    wait_clks(4);
    check("rst_start", int'(start), 0);
    check("rst_frame_ok", int'(frame_ok), 0);
    check("rst_errs", int'(err_short | err_over), 0);
    check("rst_ready", int'(ready), 1);
    @(negedge clk) rst = 0;
    wait_clks(4);

    do_frame(FB, 1, 0);
    @(negedge clk) rd_addr = 4'd5;
    @(negedge clk) check("rd_addr5", int'(rd_data), 5);
    check_ram();

    do_frame(7, 0, 0);
    check_ram();

    do_frame(15, 0, 0);
    check_ram();

    busy = 1;
    do_frame(FB, 0, 1);
    do_frame(FB, 0, 1);
    s0 = n_start; r0 = n_ready;
    wait_clks(100);
    check("busy_ready_low", n_ready - r0, 0);
    @(negedge clk) begin busy = 0; drop_cyc = cyc; end
    wait_clks(6);
    check("busy_start_once", n_start - s0, 1);
    check("busy_start_delay", start_cyc - drop_cyc, 1);
    check("busy_ready_after", int'(ready), 1);
    check_ram();

    sh0 = n_short;
    cs_n = 0; #200;
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom));
    #200 cs_n = 1;
    wait_clks(12);
    check("partial_short", n_short - sh0, 1);
    #200;
    do_frame(FB, 0, 0);
    check_ram();

    s0 = n_start; o0 = n_ok; sh0 = n_short; ov0 = n_over;
    cs_n = 0; #200;
    for (int i = 0; i < 5; i++) begin
      ref_ram[i] = 8'($urandom);
      spi_byte(ref_ram[i]);
    end
    for (int i = 0; i < 3; i++) spi_bit(1'($urandom));
    @(negedge clk) rst = 1;
    #100 cs_n = 1;
    repeat (5) @(negedge clk);
    check("midrst_pulses", int'(start | frame_ok | err_short | err_over), 0);
    rst = 0;
    wait_clks(20);
    check("midrst_counts", (n_start - s0) + (n_ok - o0) + (n_short - sh0) + (n_over - ov0), 0);
    #200;
    do_frame(FB, 0, 0);
    check_ram();

    for (int k = 0; k < 10; k++) begin
      do_frame(int'($urandom_range(0, 16)), 0, 0);
      check_ram();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
